program_counter_unit: RTL and testbench

PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

---
 rtl/program_counter_unit_pkg.sv | 16 +
 rtl/program_counter_unit_ras.sv | 99 +++++++++
 rtl/program_counter_unit.sv | 155 +++++++++++++++
 tb/tb_program_counter_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/program_counter_unit_pkg.sv
// Shared definitions for the program counter unit: next-PC select
// encodings and the default instruction step.
package program_counter_unit_pkg;

    // Next-PC select encodings carried on PC_FS.
    typedef enum logic [1:0] {
        PCFS_HOLD = 2'b00,
        PCFS_INC  = 2'b01,
        PCFS_REL  = 2'b10,
        PCFS_ABS  = 2'b11
    } pc_fs_e;

    // Byte increment per instruction (32-bit instruction words).
    localparam int unsigned DEFAULT_STEP = 4;

endpackage

// File: rtl/program_counter_unit_ras.sv
// pc_ras: circular return-address stack for the program counter unit.
// The write pointer wraps modulo DEPTH, so a push into a full stack lands
// on the oldest entry; occupancy saturates at DEPTH and the sticky error
// flag records the lost entry. A pop or replace on an empty stack changes
// nothing but the error flag. Stack contents are not reset.
module pc_ras #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          replace_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] top_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          err_q, err_d;
    logic [AW-1:0] top_idx;

    // ptr_q is the next free slot, so the top entry sits one below it.
    assign top_idx = ptr_q - PTR_ONE;
    assign top_o   = mem_q[top_idx];
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign err_o   = err_q;

    // Pointer, occupancy and error next-state from the requested operation.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_ONE;
            if (count_q == CNT_FULL) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else if (pop_i) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - PTR_ONE;
                count_d = count_q - CNT_ONE;
            end
        end else if (replace_i) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
    end

    // Control state: reset wins over the enable; disabled means frozen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (en_i) begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Entry storage: push writes the free slot, replace rewrites the top.
    always_ff @(posedge clk_i) begin
        if (!rst_i && en_i) begin
            if (push_i) begin
                mem_q[ptr_q] <= data_i;
            end else if (replace_i && (count_q != '0)) begin
                mem_q[top_idx] <= data_i;
            end
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// program_counter_unit: registered PC with increment, relative branch,
// absolute load and a return-address stack (pc_ras).
// Optional feature macro: PC_ALIGN_CHECK_EN. When defined, a misaligned
// absolute load or return raises the sticky pc_fault output and leaves the
// PC unchanged; when undefined, loaded PCs have their low bits cleared.
// STEP is assumed to be a power of two.
module program_counter_unit
    import program_counter_unit_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned K_W       = 32,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned STEP      = DEFAULT_STEP
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic [1:0]      PC_FS,
    input  logic [K_W-1:0]  k,
    input  logic [PC_W-1:0] target,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] PC_out,
    output logic [PC_W-1:0] PC_plus,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            pc_fault
`endif
);

    localparam int unsigned   SHIFT    = $clog2(STEP);
    localparam logic [PC_W-1:0] STEP_V   = PC_W'(STEP);
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(STEP - 1);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_rel;
    logic [PC_W-1:0] k_ext;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] load_val;
    logic            load_req;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_replace;

    // Sign-extend (or truncate) the word offset to the PC width.
    generate
        if (K_W >= PC_W) begin : g_k_trunc
            assign k_ext = k[PC_W-1:0];
        end else begin : g_k_sext
            assign k_ext = {{(PC_W - K_W){k[K_W-1]}}, k};
        end
    endgenerate

    assign pc_inc  = pc_q + STEP_V;
    assign pc_rel  = pc_q + (k_ext << SHIFT);
    assign PC_out  = pc_q;
    assign PC_plus = pc_inc;

    // Stack requests: ret dominates; call only pushes on a taken branch;
    // call together with ret swaps the top for the new return address.
    assign ras_push    = call && !ret && PC_FS[1];
    assign ras_pop     = ret && !call;
    assign ras_replace = ret && call;

    pc_ras #(
        .DW    (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i     (clock),
        .rst_i     (reset),
        .en_i      (!stall),
        .push_i    (ras_push),
        .pop_i     (ras_pop),
        .replace_i (ras_replace),
        .data_i    (pc_inc),
        .top_o     (ras_top),
        .empty_o   (ras_empty),
        .full_o    (ras_full),
        .err_o     (ras_err)
    );

    // Select the load source (return address or bus target) or the
    // arithmetic next PC; a return on an empty stack falls through to +STEP.
    always_comb begin
        pc_d     = pc_q;
        load_req = 1'b0;
        load_val = '0;
        if (ret) begin
            if (!ras_empty) begin
                load_req = 1'b1;
                load_val = ras_top;
            end else begin
                pc_d = pc_inc;
            end
        end else begin
            case (pc_fs_e'(PC_FS))
                PCFS_HOLD: pc_d = pc_q;
                PCFS_INC:  pc_d = pc_inc;
                PCFS_REL:  pc_d = pc_rel;
                PCFS_ABS: begin
                    load_req = 1'b1;
                    load_val = target;
                end
                default:   pc_d = pc_q;
            endcase
        end
`ifndef PC_ALIGN_CHECK_EN
        if (load_req) begin
            pc_d = load_val & ~LOW_MASK;
        end
`endif
`ifdef PC_ALIGN_CHECK_EN
        if (load_req && ((load_val & LOW_MASK) == '0)) begin
            pc_d = load_val;
        end
`endif
    end

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign pc_fault = fault_q;

    // A misaligned load keeps the PC (pc_d defaults to pc_q) and latches the fault.
    always_comb begin
        fault_d = fault_q;
        if (load_req && ((load_val & LOW_MASK) != '0)) begin
            fault_d = 1'b1;
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (!stall) begin
            fault_q <= fault_d;
        end
    end
`endif

    // PC register: reset beats stall, stall freezes the PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= '0;
        end else if (!stall) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_program_counter_unit.sv
// Testbench for program_counter_unit with a queue-based scoreboard.
// Inputs are driven before each rising edge; the expected post-edge state
// is queued and a negedge monitor pops and compares it.
// Build with +define+PC_ALIGN_CHECK_EN to exercise the alignment fault.
module tb_program_counter_unit;

  localparam int W = 68;  // {PC_out, PC_plus, empty, full, err, fault}

  logic        clock = 1'b0;
  logic        reset, stall, call, ret;
  logic [1:0]  PC_FS;
  logic [31:0] k, target;
  logic [31:0] PC_out, PC_plus;
  logic        ras_empty, ras_full, ras_err;
  logic        fault_act;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           failures = 0;

`ifdef PC_ALIGN_CHECK_EN
  logic pc_fault;
  assign fault_act = pc_fault;
`else
  assign fault_act = 1'b0;
`endif

  program_counter_unit dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .PC_FS     (PC_FS),
    .k         (k),
    .target    (target),
    .call      (call),
    .ret       (ret),
    .PC_out    (PC_out),
    .PC_plus   (PC_plus),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
`ifdef PC_ALIGN_CHECK_EN
    .ras_err   (ras_err),
    .pc_fault  (pc_fault)
`else
    .ras_err   (ras_err)
`endif
  );

  // Clock
  always #5 clock = ~clock;

  // Driver: apply one cycle of inputs, then queue the expected result.
  task automatic drive(input string nm, input logic rst, input logic st,
                       input logic [1:0] fs, input logic [31:0] kk,
                       input logic [31:0] tgt, input logic c, input logic r,
                       input logic [31:0] e_pc, input logic e_empty,
                       input logic e_full, input logic e_err, input logic e_fault);
    reset = rst; stall = st; PC_FS = fs; k = kk; target = tgt; call = c; ret = r;
    @(posedge clock);
    #1;
    exp_q.push_back({e_pc, e_pc + 32'd4, e_empty, e_full, e_err, e_fault});
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {PC_out, PC_plus, ras_empty, ras_full, ras_err, fault_act};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got pc=%h plus=%h e/f/err/flt=%b expected pc=%h plus=%h e/f/err/flt=%b",
                 nm, a[67:36], a[35:4], a[3:0], e[67:36], e[35:4], e[3:0]);
      end
    end
  end

  initial begin
    logic fault_exp;
    logic [31:0] align_pc;
`ifdef PC_ALIGN_CHECK_EN
    fault_exp = 1'b1; align_pc = 32'h0;
`else
    fault_exp = 1'b0; align_pc = 32'h100;
`endif
    //      name        rst st fs     k             target        c  r   pc            emp full err flt
    drive("reset",      1, 0, 2'b00, 32'd0,        32'd0,        0, 0,  32'h0,        1, 0, 0, 0);
    drive("inc1",       0, 0, 2'b01, 32'd0,        32'd0,        0, 0,  32'h4,        1, 0, 0, 0);
    drive("inc2",       0, 0, 2'b01, 32'd0,        32'd0,        0, 0,  32'h8,        1, 0, 0, 0);
    drive("inc3",       0, 0, 2'b01, 32'd0,        32'd0,        0, 0,  32'hC,        1, 0, 0, 0);
    drive("abs_10",     0, 0, 2'b11, 32'd0,        32'h10,       0, 0,  32'h10,       1, 0, 0, 0);
    drive("rel_neg2",   0, 0, 2'b10, 32'hFFFFFFFE, 32'd0,        0, 0,  32'h08,       1, 0, 0, 0);
    drive("abs_10b",    0, 0, 2'b11, 32'd0,        32'h10,       0, 0,  32'h10,       1, 0, 0, 0);
    drive("rel_pos3",   0, 0, 2'b10, 32'd3,        32'd0,        0, 0,  32'h1C,       1, 0, 0, 0);
    drive("abs_20",     0, 0, 2'b11, 32'd0,        32'h20,       0, 0,  32'h20,       1, 0, 0, 0);
    drive("call_100",   0, 0, 2'b11, 32'd0,        32'h100,      1, 0,  32'h100,      0, 0, 0, 0);
    drive("ret_24",     0, 0, 2'b00, 32'd0,        32'd0,        0, 1,  32'h24,       1, 0, 0, 0);
    // five calls into a four-entry stack; the fifth overwrites 0x28
    drive("call1",      0, 0, 2'b10, 32'd4,        32'd0,        1, 0,  32'h34,       0, 0, 0, 0);
    drive("call2",      0, 0, 2'b10, 32'd4,        32'd0,        1, 0,  32'h44,       0, 0, 0, 0);
    drive("call3",      0, 0, 2'b10, 32'd4,        32'd0,        1, 0,  32'h54,       0, 0, 0, 0);
    drive("call4_full", 0, 0, 2'b10, 32'd4,        32'd0,        1, 0,  32'h64,       0, 1, 0, 0);
    drive("call5_ovf",  0, 0, 2'b10, 32'd4,        32'd0,        1, 0,  32'h74,       0, 1, 1, 0);
    drive("ret1",       0, 0, 2'b00, 32'd0,        32'd0,        0, 1,  32'h68,       0, 0, 1, 0);
    drive("ret2",       0, 0, 2'b00, 32'd0,        32'd0,        0, 1,  32'h58,       0, 0, 1, 0);
    drive("ret3",       0, 0, 2'b00, 32'd0,        32'd0,        0, 1,  32'h48,       0, 0, 1, 0);
    drive("ret4",       0, 0, 2'b00, 32'd0,        32'd0,        0, 1,  32'h38,       1, 0, 1, 0);
    drive("ret5_unf",   0, 0, 2'b00, 32'd0,        32'd0,        0, 1,  32'h3C,       1, 0, 1, 0);
    drive("hold",       0, 0, 2'b00, 32'd0,        32'd0,        0, 0,  32'h3C,       1, 0, 1, 0);
    drive("call_200",   0, 0, 2'b11, 32'd0,        32'h200,      1, 0,  32'h200,      0, 0, 1, 0);
    drive("call_ret",   0, 0, 2'b01, 32'd0,        32'd0,        1, 1,  32'h40,       0, 0, 1, 0);
    drive("ret_repl",   0, 0, 2'b00, 32'd0,        32'd0,        0, 1,  32'h204,      1, 0, 1, 0);
    drive("call_inc",   0, 0, 2'b01, 32'd0,        32'd0,        1, 0,  32'h208,      1, 0, 1, 0);
    drive("stall_abs",  0, 1, 2'b11, 32'd0,        32'h40,       0, 0,  32'h208,      1, 0, 1, 0);
    drive("stall_call", 0, 1, 2'b11, 32'd0,        32'h40,       1, 0,  32'h208,      1, 0, 1, 0);
    drive("rst_stall",  1, 1, 2'b11, 32'd0,        32'h40,       1, 0,  32'h0,        1, 0, 0, 0);
    drive("abs_top",    0, 0, 2'b11, 32'd0,        32'hFFFFFFFC, 0, 0,  32'hFFFFFFFC, 1, 0, 0, 0);
    drive("inc_wrap",   0, 0, 2'b01, 32'd0,        32'd0,        0, 0,  32'h0,        1, 0, 0, 0);
    drive("rel_wrap",   0, 0, 2'b10, 32'hFFFFFFFF, 32'd0,        0, 0,  32'hFFFFFFFC, 1, 0, 0, 0);
    drive("abs_0",      0, 0, 2'b11, 32'd0,        32'h0,        0, 0,  32'h0,        1, 0, 0, 0);
    drive("abs_misal",  0, 0, 2'b11, 32'd0,        32'h102,      0, 0,  align_pc,     1, 0, 0, fault_exp);
    drive("reset_end",  1, 0, 2'b00, 32'd0,        32'd0,        0, 0,  32'h0,        1, 0, 0, 0);
    reset = 1'b0; PC_FS = 2'b00; call = 1'b0; ret = 1'b0;
    // bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      failures += exp_q.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
